// File: rtl/ddram_arbiter_if.sv
// Bundle of requester-side and DDRAM-side signals around the DDRAM arbiter.
// slave is the arbiter's view; master is the view of whatever drives requests and models the memory.
interface ddram_arbiter_if;
  logic        wr_req;
  logic [26:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        cpu_req;
  logic [26:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_ack;
  logic        vid_req;
  logic [26:0] vid_addr;
  logic [63:0] vid_data;
  logic        vid_ack;
  logic [28:0] ddram_addr;
  logic [3:0]  ddram_burstcnt;
  logic        ddram_rd;
  logic        ddram_we;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic        ddram_busy;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;
  logic        active;
  logic        rd_timeout;

  modport slave (
    input  wr_req, wr_addr, wr_data, cpu_req, cpu_addr, vid_req, vid_addr,
           ddram_busy, ddram_dout, ddram_dout_ready,
    output wr_ack, cpu_data, cpu_ack, vid_data, vid_ack,
           ddram_addr, ddram_burstcnt, ddram_rd, ddram_we, ddram_din, ddram_be,
           active, rd_timeout
  );

  modport master (
    output wr_req, wr_addr, wr_data, cpu_req, cpu_addr, vid_req, vid_addr,
           ddram_busy, ddram_dout, ddram_dout_ready,
    input  wr_ack, cpu_data, cpu_ack, vid_data, vid_ack,
           ddram_addr, ddram_burstcnt, ddram_rd, ddram_we, ddram_din, ddram_be,
           active, rd_timeout
  );
endinterface

// File: rtl/ddram_arbiter.sv
// Single-beat DDRAM Avalon arbiter for the PGM core: ROM writer (priority), 68k reads and
// video reads (round-robin), with address translation, lane steering and read timeout.
module ddram_arbiter #(
  parameter logic [28:0] BASE_WORD = 29'h0600_0000,
  parameter int          TIMEOUT   = 1023,
  parameter int          TO_W      = 10
) (
  input logic            clk_sys,
  input logic            reset,
  ddram_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT_RD = 2'd2, S_DONE = 2'd3;
  localparam logic [1:0] G_WR = 2'd0, G_CPU = 2'd1, G_VID = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        rr_vid_last_q, rr_vid_last_d;
  logic [1:0]  lane_q, lane_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [28:0] addr_q, addr_d;
  logic        rd_q, rd_d, we_q, we_d;
  logic [63:0] din_q, din_d;
  logic [7:0]  be_q, be_d;
  logic        wr_ack_q, wr_ack_d, cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d;
  logic [15:0] cpu_data_q, cpu_data_d;
  logic [63:0] vid_data_q, vid_data_d;
  logic        active_q, active_d;
  logic        to_q, to_d;

  function automatic logic [28:0] word_addr(input logic [26:0] byte_addr);
    return BASE_WORD + {5'd0, byte_addr[26:3]};
  endfunction

  function automatic logic [15:0] lane16(input logic [63:0] w, input logic [1:0] sel);
    return w[16*sel +: 16];
  endfunction

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    rr_vid_last_d = rr_vid_last_q;
    lane_d        = lane_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    rd_d          = rd_q;
    we_d          = we_q;
    din_d         = din_q;
    be_d          = be_q;
    wr_ack_d      = 1'b0;
    cpu_ack_d     = 1'b0;
    vid_ack_d     = 1'b0;
    cpu_data_d    = cpu_data_q;
    vid_data_d    = vid_data_q;
    to_d          = to_q;
    case (state_q)
      S_IDLE: begin
        if (bus.wr_req) begin
          gnt_d   = G_WR;
          addr_d  = word_addr(bus.wr_addr);
          din_d   = {4{bus.wr_data}};
          be_d    = 8'(8'b11 << {bus.wr_addr[2:1], 1'b0});
          we_d    = 1'b1;
          state_d = S_ISSUE;
        end else if (bus.cpu_req && (!bus.vid_req || rr_vid_last_q)) begin
          gnt_d   = G_CPU;
          addr_d  = word_addr(bus.cpu_addr);
          lane_d  = bus.cpu_addr[2:1];
          be_d    = 8'hFF;
          rd_d    = 1'b1;
          state_d = S_ISSUE;
        end else if (bus.vid_req) begin
          gnt_d   = G_VID;
          addr_d  = word_addr(bus.vid_addr);
          be_d    = 8'hFF;
          rd_d    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!bus.ddram_busy) begin
          rd_d = 1'b0;
          we_d = 1'b0;
          if (gnt_q == G_WR) begin
            wr_ack_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT_RD;
          end
        end
      end
      S_WAIT_RD: begin
        // A timed-out read completes with all-ones so the requester never stalls forever.
        if (bus.ddram_dout_ready || cnt_q == TO_W'(TIMEOUT - 1)) begin
          if (!bus.ddram_dout_ready) to_d = 1'b1;
          if (gnt_q == G_CPU) begin
            cpu_data_d = bus.ddram_dout_ready ? lane16(bus.ddram_dout, lane_q) : 16'hFFFF;
            cpu_ack_d  = 1'b1;
          end else begin
            vid_data_d = bus.ddram_dout_ready ? bus.ddram_dout : 64'hFFFF_FFFF_FFFF_FFFF;
            vid_ack_d  = 1'b1;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (gnt_q == G_CPU) rr_vid_last_d = 1'b0;
        else if (gnt_q == G_VID) rr_vid_last_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      gnt_q         <= G_WR;
      rr_vid_last_q <= 1'b1;
      lane_q        <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      rd_q          <= 1'b0;
      we_q          <= 1'b0;
      din_q         <= '0;
      be_q          <= '0;
      wr_ack_q      <= 1'b0;
      cpu_ack_q     <= 1'b0;
      vid_ack_q     <= 1'b0;
      cpu_data_q    <= '0;
      vid_data_q    <= '0;
      active_q      <= 1'b0;
      to_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      rr_vid_last_q <= rr_vid_last_d;
      lane_q        <= lane_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      rd_q          <= rd_d;
      we_q          <= we_d;
      din_q         <= din_d;
      be_q          <= be_d;
      wr_ack_q      <= wr_ack_d;
      cpu_ack_q     <= cpu_ack_d;
      vid_ack_q     <= vid_ack_d;
      cpu_data_q    <= cpu_data_d;
      vid_data_q    <= vid_data_d;
      active_q      <= active_d;
      to_q          <= to_d;
    end
  end

  assign bus.wr_ack         = wr_ack_q;
  assign bus.cpu_ack        = cpu_ack_q;
  assign bus.vid_ack        = vid_ack_q;
  assign bus.cpu_data       = cpu_data_q;
  assign bus.vid_data       = vid_data_q;
  assign bus.ddram_addr     = addr_q;
  assign bus.ddram_burstcnt = 4'd1;
  assign bus.ddram_rd       = rd_q;
  assign bus.ddram_we       = we_q;
  assign bus.ddram_din      = din_q;
  assign bus.ddram_be       = be_q;
  assign bus.active         = active_q;
  assign bus.rd_timeout     = to_q;

endmodule
